// File: rtl/comparador_serial.sv
// Serial MSB-first magnitude/equality comparator with Hamming distance.
// One bit pair per valid cycle; results are registered and flagged by a one-cycle done pulse.
module comparador_serial #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         bit_valid,
  input  logic                         a_bit,
  input  logic                         b_bit,
  output logic                         busy,
  output logic                         done,
  output logic                         eq,
  output logic                         gt,
  output logic                         lt,
  output logic [$clog2(WIDTH+1)-1:0]   diff_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [CW-1:0] diff_q,    diff_d;
  logic          decided_q, decided_d;
  logic          mag_gt_q,  mag_gt_d;
  logic          eq_q,      eq_d;
  logic          gt_q,      gt_d;
  logic          lt_q,      lt_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          mismatch;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    decided_d = decided_q;
    mag_gt_d  = mag_gt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    mismatch  = 1'b0;

    // start restarts the comparison from every state, including mid-word
    if (start) begin
      state_d   = ST_SHIFT;
      cnt_d     = {CW{1'b0}};
      diff_d    = {CW{1'b0}};
      decided_d = 1'b0;
      mag_gt_d  = 1'b0;
      eq_d      = 1'b0;
      gt_d      = 1'b0;
      lt_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (bit_valid) begin
            mismatch = a_bit ^ b_bit;
            cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            diff_d   = diff_q + {{(CW-1){1'b0}}, mismatch};
            // the first differing MSB-first position decides the magnitude
            if (mismatch && !decided_q) begin
              decided_d = 1'b1;
              mag_gt_d  = a_bit;
            end else begin
              decided_d = decided_q;
              mag_gt_d  = mag_gt_q;
            end
            if (cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
              eq_d    = ~decided_d;
              gt_d    = decided_d & mag_gt_d;
              lt_d    = decided_d & ~mag_gt_d;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      diff_q    <= {CW{1'b0}};
      decided_q <= 1'b0;
      mag_gt_q  <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      decided_q <= decided_d;
      mag_gt_q  <= mag_gt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign eq         = eq_q;
  assign gt         = gt_q;
  assign lt         = lt_q;
  assign diff_count = diff_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed and randomized bench for comparador_serial; expectations come from whole-word
// arithmetic (==, >, <, popcount of XOR) rather than bit-serial tracking.
module tb_comparador_serial;

  localparam int W  = 8;
  localparam int DW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [DW-1:0] diff_count;

  int n_vec;
  int n_err;
  bit started;

  comparador_serial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_valid  (bit_valid),
    .a_bit      (a_bit),
    .b_bit      (b_bit),
    .busy       (busy),
    .done       (done),
    .eq         (eq),
    .gt         (gt),
    .lt         (lt),
    .diff_count (diff_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_eq"},   {31'd0, eq},   32'd0);
    chk({tag, "_gt"},   {31'd0, gt},   32'd0);
    chk({tag, "_lt"},   {31'd0, lt},   32'd0);
    chk({tag, "_diff"}, 32'(diff_count), 32'd0);
  endtask

  task automatic do_start();
    start     = 1'b1;
    bit_valid = 1'b0;
    tick();
    start     = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk_cleared("start");
  endtask

  // Feeds one word pair MSB first; optional valid gap after gap_at consumed bits,
  // optional start in the DONE cycle.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gap_at, input int gap_len, input bit restart_after);
    logic [31:0] e_eq, e_gt, e_lt, e_diff;
    e_eq   = (a == b) ? 32'd1 : 32'd0;
    e_gt   = (a >  b) ? 32'd1 : 32'd0;
    e_lt   = (a <  b) ? 32'd1 : 32'd0;
    e_diff = 32'($countones(a ^ b));
    for (int i = W - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      tick();
      if (i > 0) begin
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_done", {31'd0, done}, 32'd0);
        if (gap_at > 0 && (W - i) == gap_at) begin
          for (int g = 0; g < gap_len; g++) begin
            bit_valid = 1'b0;
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_done", {31'd0, done}, 32'd0);
          end
        end
      end
    end
    chk("res_done", {31'd0, done}, 32'd1);
    chk("res_busy", {31'd0, busy}, 32'd0);
    chk("res_eq",   {31'd0, eq},   e_eq);
    chk("res_gt",   {31'd0, gt},   e_gt);
    chk("res_lt",   {31'd0, lt},   e_lt);
    chk("res_diff", 32'(diff_count), e_diff);
    if (restart_after) begin
      start     = 1'b1;
      bit_valid = 1'b0;
      tick();
      start     = 1'b0;
      chk("rs_busy", {31'd0, busy}, 32'd1);
      chk_cleared("rs");
    end else begin
      // bits offered in the DONE cycle must be ignored
      bit_valid = 1'b1;
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      tick();
      bit_valid = 1'b0;
      chk("hold_done", {31'd0, done}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd0);
      chk("hold_eq",   {31'd0, eq},   e_eq);
      chk("hold_gt",   {31'd0, gt},   e_gt);
      chk("hold_lt",   {31'd0, lt},   e_lt);
      chk("hold_diff", 32'(diff_count), e_diff);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] fa, fb;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_cleared("rst");

    // bits in IDLE are ignored
    for (int k = 0; k < 4; k++) begin
      bit_valid = 1'b1;
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
    end
    bit_valid = 1'b0;

    do_start();
    send_word(8'hA5, 8'hA5, 0, 0, 1'b0);
    do_start();
    send_word(8'h80, 8'h7F, 0, 0, 1'b0);
    do_start();
    send_word(8'h12, 8'h13, 4, 3, 1'b0);

    // reset in the middle of a word
    do_start();
    fa = 8'hFF;
    fb = 8'h00;
    for (int i = W - 1; i >= W - 5; i--) begin
      bit_valid = 1'b1;
      a_bit     = fa[i];
      b_bit     = fb[i];
      tick();
    end
    rst       = 1'b1;
    bit_valid = 1'b1;
    start     = 1'b1;
    tick();
    rst       = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk_cleared("mrst");
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("mrst_nodone", {31'd0, done}, 32'd0);
    end
    do_start();
    send_word(8'h01, 8'h00, 0, 0, 1'b0);

    // restart after 3 bits, with a valid bit in the restart cycle
    do_start();
    fa = 8'hFF;
    fb = 8'h00;
    for (int i = W - 1; i >= W - 3; i--) begin
      bit_valid = 1'b1;
      a_bit     = fa[i];
      b_bit     = fb[i];
      tick();
    end
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    tick();
    start     = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk_cleared("abort");
    send_word(8'h3C, 8'h3C, 0, 0, 1'b1);
    started = 1'b1;

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      if (!started) do_start();
      started = ($urandom_range(0, 1) == 1);
      send_word(ra, rb, $urandom_range(0, W - 1), $urandom_range(0, 3), started);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
